// File: rtl/ospe_result_drain.sv
// ospe_result_drain
// Read end of the output-stationary PE accumulate path. On a capture request
// all N lane partial sums are snapshotted in one cycle, the PEs are told to
// clear their psums, and the snapshot is streamed out one lane per cycle over
// a valid/ready interface. A capture landing on the final handshake of a
// frame starts the next frame with no bubble; any other capture while
// streaming is dropped and latched as a sticky overrun.
module ospe_result_drain #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int IDXW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap,
  input  logic [N*WIDTH-1:0]   psumIn,
  output logic                 psumClr,
  output logic [WIDTH-1:0]     oData,
  output logic [IDXW-1:0]      oIdx,
  output logic                 oValid,
  input  logic                 oReady,
  output logic                 oLast,
  output logic                 busy,
  output logic                 err
);

  localparam logic STIDLE   = 1'b0;
  localparam logic STSTREAM = 1'b1;

  localparam logic [IDXW-1:0] LASTIDX = IDXW'(N - 1);

  logic             state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] buffer [N];
  logic             clrReg;
  logic             errReg;

  logic             streaming;
  logic             atLast;
  logic             accept;
  logic             lastXfer;
  logic             capOk;
  logic             overrun;

  // Handshake and capture qualification decoded from the current state.
  always_comb begin
    streaming = (state == STSTREAM);
    atLast    = (idx == LASTIDX);
    accept    = streaming && oReady;
    lastXfer  = accept && atLast;
    // A capture is only taken when the buffer is free, or is being freed by
    // the final handshake this very cycle (back-to-back frames).
    capOk     = cap && (!streaming || lastXfer);
    overrun   = cap && streaming && !lastXfer;
  end

  // Control: state, lane index, clear pulse and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STIDLE;
      idx    <= '0;
      clrReg <= 1'b0;
      errReg <= 1'b0;
    end else begin
      clrReg <= capOk;
      if (overrun) begin
        errReg <= 1'b1;
      end
      if (capOk) begin
        state <= STSTREAM;
        idx   <= '0;
      end else if (lastXfer) begin
        state <= STIDLE;
        idx   <= '0;
      end else if (accept) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  // Snapshot bank: one N*WIDTH register set, loaded only on an accepted capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        buffer[i] <= '0;
      end
    end else if (capOk) begin
      for (int i = 0; i < N; i++) begin
        buffer[i] <= psumIn[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output view of the stream; data is a straight lane select, bit-exact.
  always_comb begin
    oValid  = streaming;
    busy    = streaming;
    oLast   = streaming && atLast;
    oIdx    = idx;
    oData   = buffer[idx];
    psumClr = clrReg;
    err     = errReg;
  end

endmodule
